// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I core constants, IFU state encoding and IF/ID record.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0
    localparam logic [XLEN-1:0] RV_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFU_BOOT  = 2'd0,
        IFU_FETCH = 2'd1,
        IFU_DRAIN = 2'd2,
        IFU_HOLD  = 2'd3
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/ifu_skid_buffer.sv
// ifu_skid_buffer: one-entry instruction+PC holding register. Catches a word
// the cache returned while decode was stalled so it is never fetched twice.
module ifu_skid_buffer
    import riscv_pkg::*;
(
    input  logic            gclk,
    input  logic            grst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            full,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out
);

    logic            full_q, full_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Flush beats load beats unload; a load overwrites the payload.
    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full      = full_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage. Owns the PC, drives the I-cache request
// and the IF/ID register; handles misses, redirects and decode stalls.
// Optional perf counters (FETCH_COUNT, MISS_CYCLES) under `define IFU_PERF_CNT_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RV_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic            CLK,
    input  logic            RESET_N,
    output logic [XLEN-1:0] ICACHE_ADDR,
    output logic            ICACHE_READ,
    input  logic [XLEN-1:0] ICACHE_INSTR,
    input  logic            ICACHE_BUSYWAIT,
    input  logic            STALL,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] BRANCH_TARGET,
    output logic [XLEN-1:0] IF_ID_INSTR,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_PC4,
    output logic            IF_ID_VALID
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     FETCH_COUNT,
    output logic [31:0]     MISS_CYCLES
`endif
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic [XLEN-1:0] tgt, pc_inc;
    ifid_t           ifid_q, ifid_d, bubble;
    logic            skid_load, skid_unload, skid_flush, skid_full;
    logic [XLEN-1:0] skid_instr, skid_pc;

    assign tgt    = {BRANCH_TARGET[XLEN-1:2], 2'b00};
    assign pc_inc = pc_q + 32'd4;
    // A bubble only replaces the instruction and valid; PC fields are don't-care.
    assign bubble = '{instr: NOP_INSTR, pc: ifid_q.pc, pc4: ifid_q.pc4, valid: 1'b0};

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IFU_BOOT;
        else          state_q <= state_d;
    end

    // Next-state: branch > stall > busywait; DRAIN waits out an abandoned miss.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_BOOT:  state_d = IFU_FETCH;
            IFU_FETCH: begin
                if (BRANCH_TAKEN) begin
                    if (ICACHE_BUSYWAIT) state_d = IFU_DRAIN;
                end else if (STALL && !ICACHE_BUSYWAIT) begin
                    state_d = IFU_HOLD;
                end
            end
            IFU_DRAIN: if (!ICACHE_BUSYWAIT) state_d = IFU_FETCH;
            IFU_HOLD:  if (BRANCH_TAKEN || !STALL) state_d = IFU_FETCH;
            default:   state_d = IFU_BOOT;
        endcase
    end

    // Cache request: DRAIN replays the old address so the miss completes cleanly.
    always_comb begin
        ICACHE_READ = (state_q == IFU_FETCH) || (state_q == IFU_DRAIN);
        ICACHE_ADDR = (state_q == IFU_DRAIN) ? req_addr_q : pc_q;
    end

    // PC, IF/ID and skid control for the current state.
    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        ifid_d      = ifid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        case (state_q)
            IFU_FETCH: begin
                req_addr_d = pc_q;
                if (BRANCH_TAKEN) begin
                    pc_d   = tgt;
                    ifid_d = bubble;
                end else if (STALL) begin
                    // Word arrived during a stall: park it and move past it.
                    if (!ICACHE_BUSYWAIT) begin
                        skid_load = 1'b1;
                        pc_d      = pc_inc;
                    end
                end else if (ICACHE_BUSYWAIT) begin
                    ifid_d = bubble;
                end else begin
                    ifid_d = '{instr: ICACHE_INSTR, pc: pc_q, pc4: pc_inc, valid: 1'b1};
                    pc_d   = pc_inc;
                end
            end
            IFU_DRAIN: begin
                if (BRANCH_TAKEN) pc_d = tgt;
                if (!STALL) ifid_d = bubble;
            end
            IFU_HOLD: begin
                if (BRANCH_TAKEN) begin
                    skid_flush = 1'b1;
                    pc_d       = tgt;
                    ifid_d     = bubble;
                end else if (!STALL && skid_full) begin
                    skid_unload = 1'b1;
                    ifid_d = '{instr: skid_instr, pc: skid_pc, pc4: skid_pc + 32'd4, valid: 1'b1};
                end
            end
            default: ;
        endcase
    end

    // PC, request address and IF/ID register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            ifid_q     <= '{instr: NOP_INSTR, pc: '0, pc4: 32'd4, valid: 1'b0};
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ifid_q     <= ifid_d;
        end
    end

    ifu_skid_buffer u_skid (
        .gclk      (CLK),
        .grst_n    (RESET_N),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (skid_flush),
        .instr_in  (ICACHE_INSTR),
        .pc_in     (pc_q),
        .full      (skid_full),
        .instr_out (skid_instr),
        .pc_out    (skid_pc)
    );

    assign IF_ID_INSTR = ifid_q.instr;
    assign IF_ID_PC    = ifid_q.pc;
    assign IF_ID_PC4   = ifid_q.pc4;
    assign IF_ID_VALID = ifid_q.valid;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        fetch_evt, miss_evt;

    // Count valid IF/ID loads and cache-wait cycles, saturating at all-ones.
    always_comb begin
        fetch_evt = !BRANCH_TAKEN && !STALL &&
                    (((state_q == IFU_FETCH) && !ICACHE_BUSYWAIT) ||
                     ((state_q == IFU_HOLD) && skid_full));
        miss_evt    = ICACHE_READ && ICACHE_BUSYWAIT;
        fetch_cnt_d = (fetch_evt && (fetch_cnt_q != '1)) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        miss_cnt_d  = (miss_evt && (miss_cnt_q != '1)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign FETCH_COUNT = fetch_cnt_q;
    assign MISS_CYCLES = miss_cnt_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage for the pipelined RV32I core. It owns the PC, issues read requests to the instruction cache, handles cache miss stalls, branch/jump redirects and decode-stage stalls. It drives the IF/ID pipeline register, whose instruction output feeds the decode stage (immediate generation, control decode).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0) driven into IF/ID on invalid slots.

Ports:
CLK  in  1  single clock, all state updates on rising edge
RESET_N  in  1  asynchronous, active-low reset
ICACHE_ADDR  out  32  fetch address to instruction cache
ICACHE_READ  out  1  fetch request; address held stable while BUSYWAIT high
ICACHE_INSTR  in  32  returned instruction, valid in the cycle READ=1 and BUSYWAIT=0
ICACHE_BUSYWAIT  in  1  cache miss in progress (combinational from cache)
STALL  in  1  hazard unit: hold IF/ID and PC
BRANCH_TAKEN  in  1  redirect request from EX, single-cycle pulse
BRANCH_TARGET  in  32  redirect address, word aligned
IF_ID_INSTR  out  32  registered instruction to decode
IF_ID_PC  out  32  registered PC of IF_ID_INSTR
IF_ID_PC4  out  32  IF_ID_PC + 4
IF_ID_VALID  out  1  IF/ID slot holds a real instruction

Behaviour:
- Reset (RESET_N low, asynchronous, immediate): PC=RESET_PC, state=BOOT, ICACHE_READ=0, IF_ID_INSTR=NOP_INSTR, IF_ID_PC=0, IF_ID_PC4=4, IF_ID_VALID=0, skid buffer empty. Reset mid-miss abandons the request. The cache is reset by the same net.
- States: BOOT, FETCH, DRAIN, HOLD.
- BOOT: READ=0. Moves to FETCH on the first edge after reset release.
- FETCH: READ=1, ADDR=PC, req_addr<=PC. Priority at each edge is BRANCH_TAKEN > STALL > BUSYWAIT > normal:
  - Branch, BUSYWAIT=0: PC<=TARGET; IF/ID<=NOP with VALID=0; stay in FETCH.
  - Branch, BUSYWAIT=1: PC<=TARGET; IF/ID bubble; go to DRAIN.
  - STALL, BUSYWAIT=0: returned instruction and its PC go to the skid buffer; PC<=PC+4; IF/ID held; go to HOLD.
  - STALL, BUSYWAIT=1: IF/ID and PC held; stay in FETCH.
  - BUSYWAIT=1, no stall: PC held; IF/ID<=bubble.
  - Normal: IF/ID<={ICACHE_INSTR, PC, PC+4, 1}; PC<=PC+4.
- DRAIN: READ=1, ADDR=req_addr, which keeps the old address stable for the cache. When BUSYWAIT=0 the returned data is discarded and the state goes to FETCH. A BRANCH_TAKEN in DRAIN overwrites PC only. IF/ID stays bubble, unless STALL is high, in which case it is held.
- HOLD: READ=0. While STALL=1, IF/ID is held. When STALL=0: IF/ID<=skid contents with VALID=1, skid empties, go to FETCH. A branch in HOLD flushes the skid, sets PC<=TARGET, writes an IF/ID bubble, and goes to FETCH.
- Latency: a hit fetch reaches IF/ID one cycle after the address is issued. A miss adds one bubble per BUSYWAIT cycle.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0. Bits [1:0] of PC are always 0; BRANCH_TARGET[1:0] is ignored and forced to 0.
- IF_ID_INSTR is NOP_INSTR whenever IF_ID_VALID=0.

Optional Feature:
IFU_PERF_CNT_EN: when defined, adds output ports FETCH_COUNT[31:0] (increments on each IF/ID load with VALID=1) and MISS_CYCLES[31:0] (increments each cycle READ=1 and BUSYWAIT=1). Both reset to 0 and saturate at 0xFFFF_FFFF. When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared riscv_pkg header holds NOP_INSTR, the default RESET_PC, the IFU state encodings (BOOT=0, FETCH=1, DRAIN=2, HOLD=3) and XLEN=32.
- One sub-module, ifu_skid_buffer: a one-entry instruction+PC register with load, unload and flush inputs and a full flag.

Test Plan:
- Reset release, cache always hits → ICACHE_ADDR 0x0, 0x4, 0x8 on consecutive cycles; IF_ID_PC 0x0, 0x4 one cycle later; IF_ID_VALID=1 from the second FETCH edge.
- Miss at 0x10, BUSYWAIT high 3 cycles → ADDR held at 0x10; 3 bubbles (VALID=0, INSTR=0x13); then IF_ID_PC=0x10, VALID=1; next ADDR 0x14.
- BRANCH_TAKEN with target 0x40 while fetching 0x8 (hit) → IF/ID bubble; next ADDR=0x40; IF_ID_PC=0x40 one cycle later.
- BRANCH_TAKEN with target 0x80 during a miss at 0x20 → ADDR stays 0x20 until BUSYWAIT falls; returned word is never VALID; then ADDR=0x80.
- STALL=1 in the cycle a miss at 0x30 returns 0xDEADBEEF → READ drops to 0 and IF/ID is unchanged for 2 stall cycles; on release IF_ID_INSTR=0xDEADBEEF, IF_ID_PC=0x30; next ADDR=0x34 (no duplicate fetch).
- RESET_N pulled low mid-miss → all outputs take reset values immediately; after release the first ADDR is RESET_PC.
